// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers, default thresholds and configuration check for sync_fifo_param.
package sync_fifo_pkg;

  localparam int DEF_AE_THRESH = 2;
  localparam int DEF_AF_MARGIN = 2;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

  // Pointers wrap by natural overflow, so DEPTH must be a power of two.
  function automatic bit cfg_ok(input int depth, input int af, input int ae);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 0) && (af <= depth) && (ae >= 0) && (ae <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; master = client side, slave = FIFO side.
interface sync_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  import sync_fifo_pkg::*;

  localparam int LVL_W = lvl_w(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W register array, one synchronous write port and one read port.
// Read port is registered by default, combinational when SYNC_FIFO_FWFT_EN is defined.
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered flags, exact level and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input logic               clk,
  input logic               reset,
  sync_fifo_param_if.slave  bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int LVL_W  = lvl_w(DEPTH);

  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [LVL_W-1:0]  L_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]  L_DEPTH = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  L_AF    = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0]  L_AE    = LVL_W'(AE_THRESH);

  if (!cfg_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_cfg
    $error("sync_fifo_param: DEPTH must be a power of two >= 2 and thresholds within 0..DEPTH");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q, level_nxt;
  logic              full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic              push, pop;
  logic [DATA_W-1:0] mem_rdata;

  assign push = bus.wr_en & ~full_q;
  assign pop  = bus.rd_en & ~empty_q;

  always_comb begin
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + L_ONE;
      2'b01:   level_nxt = level_q - L_ONE;
      default: level_nxt = level_q;
    endcase
  end

  // Flags are derived from level_nxt so they line up with the level they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + A_ONE;
      if (pop)  rd_ptr <= rd_ptr + A_ONE;
      level_q <= level_nxt;
      full_q  <= (level_nxt == L_DEPTH);
      empty_q <= (level_nxt == '0);
      af_q    <= (level_nxt >= L_AF);
      ae_q    <= (level_nxt <= L_AE);

      if (bus.wr_en & full_q)  ovf_q <= 1'b1;
      else if (bus.err_clr)    ovf_q <= 1'b0;

      if (bus.rd_en & empty_q) udf_q <= 1'b1;
      else if (bus.err_clr)    udf_q <= 1'b0;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push & ~reset),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .re    (pop & ~reset),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data = empty_q ? '0 : mem_rdata;
`else
  assign bus.rd_data = mem_rdata;
`endif

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW = 32;
  localparam int DP = 8;
  localparam int AF = DP - 2;
  localparam int AE = 2;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  sync_fifo_param #(
    .DATA_W    (DW),
    .DEPTH     (DP),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst, wr, rd, clr;
    logic [DW-1:0] din;
    int            lvl;
    logic          full, empty, af, ae, ovf, udf;
    logic [DW-1:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic rst, wr, rd, clr, input logic [DW-1:0] din,
                              input int lvl, input logic ovf, udf, input logic [DW-1:0] dout);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.lvl = lvl; v.ovf = ovf; v.udf = udf; v.dout = dout;
    v.full  = (lvl == DP);
    v.empty = (lvl == 0);
    v.af    = (lvl >= AF);
    v.ae    = (lvl <= AE);
    return v;
  endfunction

  // Reference model: a queue of stored words plus sticky flags.
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_dout;

  task automatic model_update(input logic rst, wr, rd, clr, input logic [DW-1:0] din);
    bit was_full, was_empty, acc_w, acc_r;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
      return;
    end
    was_full  = (mq.size() == DP);
    was_empty = (mq.size() == 0);
    acc_w = wr && !was_full;
    acc_r = rd && !was_empty;
    if (acc_r) begin
      if (FWFT) void'(mq.pop_front());
      else      m_dout = mq.pop_front();
    end
    if (acc_w) mq.push_back(din);
    if (wr && was_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && was_empty) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    if (FWFT) m_dout = (mq.size() == 0) ? '0 : mq[0];
  endtask

  task automatic drive(input logic rst, wr, rd, clr, input logic [DW-1:0] din);
    reset       = rst;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.err_clr = clr;
    bus.wr_data = din;
  endtask

  task automatic check_model(input string tag);
    int l;
    l = mq.size();
    chk({tag, ".level"},        DW'(bus.level),        DW'(l));
    chk({tag, ".full"},         DW'(bus.full),         DW'(l == DP));
    chk({tag, ".empty"},        DW'(bus.empty),        DW'(l == 0));
    chk({tag, ".almost_full"},  DW'(bus.almost_full),  DW'(l >= AF));
    chk({tag, ".almost_empty"}, DW'(bus.almost_empty), DW'(l <= AE));
    chk({tag, ".overflow"},     DW'(bus.overflow),     DW'(m_ovf));
    chk({tag, ".underflow"},    DW'(bus.underflow),    DW'(m_udf));
    chk({tag, ".rd_data"},      bus.rd_data,           m_dout);
  endtask

  task automatic step(input string tag, input logic rst, wr, rd, clr, input logic [DW-1:0] din);
    drive(rst, wr, rd, clr, din);
    @(posedge clk);
    model_update(rst, wr, rd, clr, din);
    #1;
    check_model(tag);
  endtask

  vec_t tbl[$];

  initial begin
    logic [DW-1:0] d;
    int lv;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Vector table: reset/idle, fill, overflow, clear, drain, underflow, clear.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= DP; i++)
      tbl.push_back(mk(0, 1, 0, 0, DW'(i), i, 0, 0, FWFT ? DW'(1) : DW'(0)));
    tbl.push_back(mk(0, 1, 0, 0, 32'hDEAD, DP, 1, 0, FWFT ? DW'(1) : DW'(0)));
    tbl.push_back(mk(0, 0, 0, 1, 0, DP, 0, 0, FWFT ? DW'(1) : DW'(0)));
    for (int i = 1; i <= DP; i++)
      tbl.push_back(mk(0, 0, 1, 0, 0, DP - i, 0, 0,
                       FWFT ? ((i == DP) ? DW'(0) : DW'(i + 1)) : DW'(i)));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, FWFT ? DW'(0) : DW'(DP)));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, FWFT ? DW'(0) : DW'(DP)));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
      @(posedge clk);
      #1;
      chk($sformatf("tbl[%0d].level", i),        DW'(bus.level),        DW'(tbl[i].lvl));
      chk($sformatf("tbl[%0d].full", i),         DW'(bus.full),         DW'(tbl[i].full));
      chk($sformatf("tbl[%0d].empty", i),        DW'(bus.empty),        DW'(tbl[i].empty));
      chk($sformatf("tbl[%0d].almost_full", i),  DW'(bus.almost_full),  DW'(tbl[i].af));
      chk($sformatf("tbl[%0d].almost_empty", i), DW'(bus.almost_empty), DW'(tbl[i].ae));
      chk($sformatf("tbl[%0d].overflow", i),     DW'(bus.overflow),     DW'(tbl[i].ovf));
      chk($sformatf("tbl[%0d].underflow", i),    DW'(bus.underflow),    DW'(tbl[i].udf));
      chk($sformatf("tbl[%0d].rd_data", i),      bus.rd_data,           tbl[i].dout);
    end

    // Steady level 4 with simultaneous read/write across pointer wrap.
    step("wrap.rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("wrap.fill", 0, 1, 0, 0, DW'(32'h100 + i));
    for (int i = 4; i < 24; i++) begin
      step("wrap.rw", 0, 1, 1, 0, DW'(32'h100 + i));
      chk("wrap.level_const", DW'(bus.level), DW'(4));
      chk("wrap.no_err", DW'({bus.overflow, bus.underflow}), DW'(0));
    end

    // Simultaneous read/write on empty: push only, underflow set.
    step("empty_rw.rst", 1, 0, 0, 0, 0);
    step("empty_rw", 0, 1, 1, 0, 32'h77);
    chk("empty_rw.level", DW'(bus.level), DW'(1));
    chk("empty_rw.underflow", DW'(bus.underflow), DW'(1));

    // Simultaneous read/write on full: pop only, overflow set; set wins over err_clr.
    for (int i = 0; i < DP - 1; i++) step("full_rw.fill", 0, 1, 0, 0, DW'(32'h200 + i));
    step("full_rw", 0, 1, 1, 1, 32'hBEEF);
    chk("full_rw.level", DW'(bus.level), DW'(DP - 1));
    chk("full_rw.overflow", DW'(bus.overflow), DW'(1));

    // Reset mid-burst at level 5 wins over a concurrent write.
    step("midrst.rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("midrst.fill", 0, 1, 0, 0, DW'(32'h300 + i));
    step("midrst", 1, 1, 0, 0, 32'h3FF);
    chk("midrst.level", DW'(bus.level), DW'(0));
    chk("midrst.empty", DW'(bus.empty), DW'(1));

`ifdef SYNC_FIFO_FWFT_EN
    step("fwft.write", 0, 1, 0, 0, 32'hA5);
    chk("fwft.show_a5", bus.rd_data, 32'hA5);
    step("fwft.ack", 0, 0, 1, 0, 0);
    chk("fwft.ack_empty", DW'(bus.empty), DW'(1));
    chk("fwft.ack_zero", bus.rd_data, 32'h0);
`else
    step("std.write", 0, 1, 0, 0, 32'hA5);
    chk("std.no_early_data", bus.rd_data, 32'h0);
    step("std.read", 0, 0, 1, 0, 0);
    chk("std.read_a5", bus.rd_data, 32'hA5);
`endif

    // Random traffic, alternating fill-biased and drain-biased phases.
    step("rnd.rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic r_rst, r_wr, r_rd, r_clr;
      bit fill_phase;
      fill_phase = ((i / 50) % 2) == 0;
      r_rst = ($urandom_range(0, 149) == 0);
      r_wr  = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r_rd  = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r_clr = ($urandom_range(0, 15) == 0);
      d     = $urandom;
      step($sformatf("rnd[%0d]", i), r_rst, r_wr, r_rd, r_clr, d);
    end
    lv = mq.size();
    chk("rnd.final_level", DW'(bus.level), DW'(lv));

    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
